// File: rtl/aska_switch_guard_pkg.sv
// Shared types and constants for the ASKA output-safety stage.
// Used by the guard, its legality checker and the interface.
package aska_pkg;

   localparam int N_ELEC = 4;
   localparam int DAC_W  = 6;

   typedef enum logic [1:0] {
      S_PASS  = 2'd0,
      S_BREAK = 2'd1,
      S_MAKE  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   typedef logic [1:0] fault_code_t;

   localparam fault_code_t FAULT_NONE    = 2'd0;
   localparam fault_code_t FAULT_OVERLAP = 2'd1;
   localparam fault_code_t FAULT_MULTI   = 2'd2;
   localparam fault_code_t FAULT_WDOG    = 2'd3;

   function automatic logic at_most_one(input logic [N_ELEC-1:0] v);
      return (v & (v - 1'b1)) == '0;
   endfunction

endpackage

// File: rtl/aska_switch_guard_if.sv
// Request/applied signal bundle between the pulse generator side and the guard.
interface aska_switch_guard_if;
   import aska_pkg::*;

   logic [N_ELEC-1:0] up_req;
   logic [N_ELEC-1:0] down_req;
   logic [DAC_W-1:0]  dac_req;
   logic              pulse_active_req;
   logic              fault_clear;

   logic [N_ELEC-1:0] up_switches;
   logic [N_ELEC-1:0] down_switches;
   logic [DAC_W-1:0]  DAC;
   logic              pulse_active;
   logic              fault;
   fault_code_t       fault_code;

   modport master (
      output up_req, down_req, dac_req, pulse_active_req, fault_clear,
      input  up_switches, down_switches, DAC, pulse_active, fault, fault_code
   );

   modport slave (
      input  up_req, down_req, dac_req, pulse_active_req, fault_clear,
      output up_switches, down_switches, DAC, pulse_active, fault, fault_code
   );

endinterface

// File: rtl/aska_switch_guard_check.sv
// Combinational electrode-legality check: overlap outranks multi-select.
module aska_switch_check
   import aska_pkg::*;
(
   input  logic [N_ELEC-1:0] up,
   input  logic [N_ELEC-1:0] down,
   output logic              illegal,
   output fault_code_t       code
);

   logic overlap;
   logic multi;

   assign overlap = |(up & down);
   assign multi   = !at_most_one(up) || !at_most_one(down);

   always_comb begin
      code = FAULT_NONE;
      if (overlap)    code = FAULT_OVERLAP;
      else if (multi) code = FAULT_MULTI;
   end

   assign illegal = overlap || multi;

endmodule

// File: rtl/aska_switch_guard.sv
// Break-before-make switch sequencer with DAC settling, legality checks and
// a maximum-pulse watchdog feeding a sticky fault latch.
module aska_switch_guard
   import aska_pkg::*;
#(
   parameter int DEAD_TIME = 2,
   parameter int SETTLE    = 1,
   parameter int MAX_PULSE = 40
) (
   input  logic              clk,
   input  logic              reset,
   aska_switch_guard_if.slave bus
);

   //  state   | meaning
   //  S_PASS  | target pattern applied, DAC and pulse flag pass through
   //  S_BREAK | all switches open, DAC 0, dead-time countdown
   //  S_MAKE  | target closed, DAC 0, settling countdown
   //  S_FAULT | everything off until fault_clear with an all-zero request

   localparam int MAX_DS  = (DEAD_TIME > SETTLE) ? DEAD_TIME : SETTLE;
   localparam int CNT_MAX = (MAX_DS > MAX_PULSE) ? MAX_DS : MAX_PULSE;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t            state;
   logic [N_ELEC-1:0] tgt_up, tgt_down;
   logic [N_ELEC-1:0] up_q, down_q;
   logic [DAC_W-1:0]  dac_q;
   logic              pa_q, fault_q;
   fault_code_t       code_q;
   logic [CW-1:0]     cnt, wdog;

   logic              illegal;
   fault_code_t       chk_code;
   logic              req_zero, req_new, wdog_run, wdog_hit;
   logic [CW-1:0]     wdog_inc;

   aska_switch_check u_check (
      .up      (bus.up_req),
      .down    (bus.down_req),
      .illegal (illegal),
      .code    (chk_code)
   );

   assign req_zero = ~|{bus.up_req, bus.down_req};
   assign req_new  = {bus.up_req, bus.down_req} != {tgt_up, tgt_down};
   assign wdog_inc = wdog + 1'b1;
   assign wdog_run = (state == S_PASS) && (|{up_q, down_q}) && (|dac_q);
   assign wdog_hit = wdog_run && (wdog_inc >= CW'(MAX_PULSE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_PASS;
         tgt_up   <= '0;
         tgt_down <= '0;
         up_q     <= '0;
         down_q   <= '0;
         dac_q    <= '0;
         pa_q     <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= FAULT_NONE;
         cnt      <= '0;
         wdog     <= '0;
      end else begin
         wdog <= wdog_run ? (wdog_hit ? CW'(MAX_PULSE) : wdog_inc) : '0;

         if (state != S_FAULT && (illegal || wdog_hit)) begin
            // Legality outranks the watchdog when both trip together.
            state    <= S_FAULT;
            tgt_up   <= '0;
            tgt_down <= '0;
            up_q     <= '0;
            down_q   <= '0;
            dac_q    <= '0;
            pa_q     <= 1'b0;
            fault_q  <= 1'b1;
            code_q   <= illegal ? chk_code : FAULT_WDOG;
            cnt      <= '0;
            wdog     <= '0;
         end else if (state == S_FAULT) begin
            up_q   <= '0;
            down_q <= '0;
            dac_q  <= '0;
            pa_q   <= 1'b0;
            if (bus.fault_clear && req_zero) begin
               state    <= S_PASS;
               tgt_up   <= '0;
               tgt_down <= '0;
               fault_q  <= 1'b0;
               code_q   <= FAULT_NONE;
               dac_q    <= bus.dac_req;
               pa_q     <= bus.pulse_active_req;
            end
         end else if (req_zero || (state == S_PASS && !req_new)) begin
            // Opening (or holding the current pattern) needs no sequencing.
            state    <= S_PASS;
            tgt_up   <= bus.up_req;
            tgt_down <= bus.down_req;
            up_q     <= bus.up_req;
            down_q   <= bus.down_req;
            dac_q    <= bus.dac_req;
            pa_q     <= bus.pulse_active_req;
         end else if (req_new) begin
            state    <= S_BREAK;
            tgt_up   <= bus.up_req;
            tgt_down <= bus.down_req;
            cnt      <= CW'(DEAD_TIME - 1);
            up_q     <= '0;
            down_q   <= '0;
            dac_q    <= '0;
            pa_q     <= 1'b0;
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else if (state == S_BREAK && SETTLE != 0) begin
            state  <= S_MAKE;
            cnt    <= CW'(SETTLE - 1);
            up_q   <= tgt_up;
            down_q <= tgt_down;
         end else begin
            state  <= S_PASS;
            up_q   <= tgt_up;
            down_q <= tgt_down;
            dac_q  <= bus.dac_req;
            pa_q   <= bus.pulse_active_req;
         end
      end
   end

   assign bus.up_switches   = up_q;
   assign bus.down_switches = down_q;
   assign bus.DAC           = dac_q;
   assign bus.pulse_active  = pa_q;
   assign bus.fault         = fault_q;
   assign bus.fault_code    = code_q;

endmodule

// File: tb/tb_aska_switch_guard.sv
// Directed bench for aska_switch_guard with default timing parameters.
module tb_aska_switch_guard;
   import aska_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   aska_switch_guard_if bus ();

   logic        ref_illegal;
   fault_code_t ref_code;

   aska_switch_guard #(.DEAD_TIME(2), .SETTLE(1), .MAX_PULSE(40)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   aska_switch_check u_ref (
      .up      (bus.up_req),
      .down    (bus.down_req),
      .illegal (ref_illegal),
      .code    (ref_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] up, input logic [3:0] dn, input logic [5:0] dac,
                        input logic pa, input logic fc);
      bus.up_req           = up;
      bus.down_req         = dn;
      bus.dac_req          = dac;
      bus.pulse_active_req = pa;
      bus.fault_clear      = fc;
   endtask

   task automatic check_out(input string tag, input logic [3:0] up, input logic [3:0] dn,
                            input logic [5:0] dac, input logic pa, input logic f,
                            input logic [1:0] code);
      check_eq(tag,
               {14'd0, bus.up_switches, bus.down_switches, bus.DAC, bus.pulse_active,
                bus.fault, bus.fault_code},
               {14'd0, up, dn, dac, pa, f, code});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive(4'b0000, 4'b0000, 6'd0, 1'b0, 1'b0);
      step();
      step();
      check_out("reset", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);

      // First pattern: 2 BREAK, 1 MAKE, then PASS
      reset = 1'b0;
      drive(4'b1000, 4'b0001, 6'd10, 1'b1, 1'b0);
      step(); check_out("first_brk1", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("first_brk2", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("first_make", 4'h8, 4'h1, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("first_pass", 4'h8, 4'h1, 6'd10, 1'b1, 1'b0, 2'd0);
      drive(4'b1000, 4'b0001, 6'd10, 1'b0, 1'b0);
      step(); check_out("pass_pa_low", 4'h8, 4'h1, 6'd10, 1'b0, 1'b0, 2'd0);

      // Polarity swap
      drive(4'b0001, 4'b1000, 6'd10, 1'b1, 1'b0);
      step(); check_out("swap_brk1", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("swap_brk2", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("swap_make", 4'h1, 4'h8, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("swap_pass", 4'h1, 4'h8, 6'd10, 1'b1, 1'b0, 2'd0);

      // Overlap fault, clear rules
      drive(4'b0100, 4'b0100, 6'd10, 1'b1, 1'b0);
      #1 check_eq("ref_overlap", {30'd0, ref_code}, 32'd1);
      step(); check_out("ovl_fault", 4'h0, 4'h0, 6'd0, 1'b0, 1'b1, 2'd1);
      drive(4'b0100, 4'b0100, 6'd10, 1'b1, 1'b1);
      step(); check_out("ovl_clr_ignored", 4'h0, 4'h0, 6'd0, 1'b0, 1'b1, 2'd1);
      drive(4'b0000, 4'b0000, 6'd0, 1'b0, 1'b1);
      step(); check_out("ovl_cleared", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);

      // Multi-select fault
      drive(4'b0011, 4'b0100, 6'd10, 1'b1, 1'b0);
      #1 check_eq("ref_multi", {30'd0, ref_code}, 32'd2);
      step(); check_out("multi_fault", 4'h0, 4'h0, 6'd0, 1'b0, 1'b1, 2'd2);
      drive(4'b0000, 4'b0000, 6'd0, 1'b0, 1'b1);
      step(); check_out("multi_cleared", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);

      // Watchdog: 40 cycles of current allowed, fault on the next edge
      drive(4'b0010, 4'b0100, 6'd10, 1'b1, 1'b0);
      step(); step(); step();
      for (int i = 0; i < 40; i++) begin
         step(); check_out("wdog_run", 4'h2, 4'h4, 6'd10, 1'b1, 1'b0, 2'd0);
      end
      step(); check_out("wdog_fault", 4'h0, 4'h0, 6'd0, 1'b0, 1'b1, 2'd3);
      drive(4'b0000, 4'b0000, 6'd0, 1'b0, 1'b1);
      step(); check_out("wdog_cleared", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);

      // Same pattern with DAC=0 never trips the watchdog
      drive(4'b0010, 4'b0100, 6'd0, 1'b1, 1'b0);
      step(); step(); step();
      for (int i = 0; i < 100; i++) step();
      check_out("dac0_no_fault", 4'h2, 4'h4, 6'd0, 1'b1, 1'b0, 2'd0);

      // Requests changing every cycle keep restarting BREAK
      drive(4'b0001, 4'b0010, 6'd5, 1'b1, 1'b0);
      step(); check_out("churn_a", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      drive(4'b0100, 4'b1000, 6'd5, 1'b1, 1'b0);
      step(); check_out("churn_b", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      drive(4'b1000, 4'b0100, 6'd5, 1'b1, 1'b0);
      step(); check_out("churn_c", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("churn_quiet2", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("churn_make", 4'h8, 4'h4, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("churn_pass", 4'h8, 4'h4, 6'd5, 1'b1, 1'b0, 2'd0);

      // All-zero request during BREAK returns straight to PASS
      drive(4'b0001, 4'b0010, 6'd5, 1'b1, 1'b0);
      step(); check_out("zero_brk", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      drive(4'b0000, 4'b0000, 6'd3, 1'b1, 1'b0);
      step(); check_out("zero_pass", 4'h0, 4'h0, 6'd3, 1'b1, 1'b0, 2'd0);

      // Reset in MAKE, then the held request sequences from scratch
      drive(4'b0001, 4'b0010, 6'd7, 1'b1, 1'b0);
      step(); step();
      step(); check_out("rst_make", 4'h1, 4'h2, 6'd0, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      step(); check_out("rst_mid_make", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      reset = 1'b0;
      step(); check_out("rst_brk1", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("rst_brk2", 4'h0, 4'h0, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("rst_make2", 4'h1, 4'h2, 6'd0, 1'b0, 1'b0, 2'd0);
      step(); check_out("rst_pass", 4'h1, 4'h2, 6'd7, 1'b1, 1'b0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
